// File: rtl/fft_frame_ctrl_if.sv
// Sample-stream side of the FFT frame sequencer: ADC samples in, FFT strobe/sample out.
interface fft_frame_ctrl_if #(
   parameter int LOG2N = 10
);
   logic [11:0]      data;
   logic             data_valid;
   logic             buff_full;
   logic             fft_enable;
   logic [15:0]      fft_data;
   logic             frame_start;
   logic [LOG2N-1:0] sample_idx;

   modport master (
      input  data, data_valid, buff_full,
      output fft_enable, fft_data, frame_start, sample_idx
   );

   modport slave (
      output data, data_valid, buff_full,
      input  fft_enable, fft_data, frame_start, sample_idx
   );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Gates ADC samples into the streaming FFT in whole frames, holds at frame edges while
// the output buffer is full, and zero-flushes the pipeline when acquisition stops.
module fft_frame_ctrl #(
   parameter int LOG2N       = 10,
   parameter int FFT_LATENCY = 1100
) (
   input  logic                 CLK,
   input  logic                 rst,
   input  logic                 run,
   input  logic                 single,
   fft_frame_ctrl_if.master     io,
   output logic                 busy,
   output logic [15:0]          frame_count,
   output logic [15:0]          drop_count
);
   localparam int FW = $clog2(FFT_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, FILL, HOLD, FLUSH} state_t;

   state_t           state, state_nx;
   logic [LOG2N-1:0] idx;
   logic [FW-1:0]    flush_cnt;
   logic             single_req, single_mode;

   logic             start, last_smp, flush_slot, flush_done;
   logic             en_nx, fs_nx, drop_nx;
   logic [15:0]      data_nx;

   assign start      = (state == IDLE) && (run || single_req) && !io.buff_full;
   assign last_smp   = (state == FILL) && io.data_valid && (idx == '1);
   assign flush_slot = (state == FLUSH) && !io.buff_full;
   assign flush_done = flush_slot && (flush_cnt == FW'(FFT_LATENCY - 1));

   // state register plus the bookkeeping that moves with it
   always_ff @(posedge CLK) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         flush_cnt   <= '0;
         single_req  <= 1'b0;
         single_mode <= 1'b0;
      end else begin
         state <= state_nx;
         if (start)      idx <= '0;
         else if (en_nx) idx <= idx + LOG2N'(1);
         if (state != FLUSH)  flush_cnt <= '0;
         else if (flush_slot) flush_cnt <= flush_cnt + FW'(1);
         // entry to FILL consumes the request, even one arriving on the same edge
         if (start)                              single_req <= 1'b0;
         else if (single && (state == IDLE))     single_req <= 1'b1;
         if (start) single_mode <= !run;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start) state_nx = FILL;
         FILL:
            if (last_smp) begin
               if (single_mode || !run) state_nx = FLUSH;
               else if (io.buff_full)   state_nx = HOLD;
               else                     state_nx = FILL;
            end
         HOLD:
            if (!run)               state_nx = FLUSH;
            else if (!io.buff_full) state_nx = FILL;
         FLUSH: if (flush_done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      en_nx   = ((state == FILL) && io.data_valid) || flush_slot;
      fs_nx   = (state == FILL) && io.data_valid && (idx == '0);
      drop_nx = ((state == HOLD) || (state == FLUSH)) && io.data_valid;
      data_nx = (state == FILL) ? {{4{io.data[11]}}, io.data} : 16'h0000;
   end

   // every output leaves from a flop, one cycle behind the sampling edge
   always_ff @(posedge CLK) begin
      if (rst) begin
         io.fft_enable  <= 1'b0;
         io.fft_data    <= '0;
         io.frame_start <= 1'b0;
         io.sample_idx  <= '0;
         busy           <= 1'b0;
         frame_count    <= '0;
         drop_count     <= '0;
      end else begin
         io.fft_enable  <= en_nx;
         io.frame_start <= fs_nx;
         if (en_nx) begin
            io.fft_data   <= data_nx;
            io.sample_idx <= idx;
         end
         busy <= (state_nx != IDLE);
         if (last_smp) frame_count <= frame_count + 16'd1;
         if (drop_nx && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      end
   end
endmodule
